route_buffer: RTL

Parametrised intermediate register bank between the M1 compute array and the M2 lookup stage. Captures a full M1 result vector in one cycle, accepts per-lane sigmoid feedback overwrites, and serves lanes to M2 either by random-access read or by an autonomous valid/ready stream sequencer. An optional output mux selects between buffered data and GSRAM data for the LUT path.

---
 rtl/route_buffer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/route_buffer.sv
// Lane register bank between M1 and M2: bulk capture, per-lane feedback writes,
// random-access read and a valid/ready lane streamer. Optional LUT-path mux: ROUTE_BUFFER_SRAM_MUX_EN.
module route_buffer_lane #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (we) q <= d;
    end
endmodule

module route_buffer #(
    parameter int DW    = 16,
    parameter int LANES = 10,
    parameter int AW    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                gate,
    input  logic                bulk_load,
    input  logic [LANES*DW-1:0] bulk_data,
    input  logic                fb_we,
    input  logic [AW-1:0]       fb_addr,
    input  logic [DW-1:0]       fb_data,
    input  logic                rd_en,
    input  logic [AW-1:0]       rd_addr,
    output logic [DW-1:0]       rd_data,
    input  logic                stream_start,
    output logic                m2_valid,
    input  logic                m2_ready,
    output logic [DW-1:0]       m2_data,
    output logic                m2_last,
    output logic                busy,
    output logic                done,
    output logic                err,
    input  logic                out_sel,
    input  logic [DW-1:0]       sram_data,
    output logic [DW-1:0]       data_out
);
    localparam logic [0:0]    ST_IDLE   = 1'b0;
    localparam logic [0:0]    ST_STREAM = 1'b1;
    localparam logic [AW:0]   LANES_W   = (AW+1)'(LANES);
    localparam logic [AW-1:0] LAST_IDX  = AW'(LANES-1);

    logic [LANES-1:0][DW-1:0] lane_q;
    logic [0:0]               state_q;
    logic [AW-1:0]            idx_q;
    logic [AW-1:0]            idx_nxt;
    logic                     streaming;
    logic                     fb_in_range, rd_in_range;
    logic                     bulk_ok, fb_wr, err_nxt;

    assign streaming   = (state_q == ST_STREAM);
    assign fb_in_range = ({1'b0, fb_addr} < LANES_W);
    assign rd_in_range = ({1'b0, rd_addr} < LANES_W);
    assign idx_nxt     = idx_q + AW'(1);

    // bulk_load is rejected while streaming, so it only wins over fb_we in IDLE
    assign bulk_ok = bulk_load & ~streaming;
    assign fb_wr   = fb_we & ~bulk_ok & fb_in_range;
    assign err_nxt = (fb_we & ~bulk_ok & ~fb_in_range)
                   | (rd_en & ~rd_in_range)
                   | (streaming & (stream_start | bulk_load));

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic          we;
        logic [DW-1:0] d;
        assign we = gate & (bulk_ok | (fb_wr & (fb_addr == AW'(i))));
        assign d  = bulk_ok ? bulk_data[i*DW +: DW] : fb_data;
        route_buffer_lane #(.DW(DW)) u_lane (
            .clk (clk),
            .rst (rst),
            .we  (we),
            .d   (d),
            .q   (lane_q[i])
        );
    end

    // Reads and stream fetches sample lane_q before this cycle's writes land
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            m2_data <= '0;
            rd_data <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else if (gate) begin
            done <= 1'b0;
            err  <= err_nxt;
            if (rd_en)
                rd_data <= rd_in_range ? lane_q[rd_addr] : '0;
            if (streaming) begin
                if (m2_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_IDLE;
                        done    <= 1'b1;
                    end else begin
                        idx_q   <= idx_nxt;
                        m2_data <= lane_q[idx_nxt];
                    end
                end
            end else if (stream_start) begin
                state_q <= ST_STREAM;
                idx_q   <= '0;
                m2_data <= lane_q[0];
            end
        end
    end

    assign busy     = streaming;
    assign m2_valid = streaming;
    assign m2_last  = streaming & (idx_q == LAST_IDX);

`ifdef ROUTE_BUFFER_SRAM_MUX_EN
    assign data_out = out_sel ? sram_data : rd_data;
`else
    logic unused_mux;
    assign unused_mux = &{1'b0, out_sel, sram_data};
    assign data_out   = rd_data;
`endif
endmodule
